// File: rtl/beamformer_index_loader.sv
// Loads the strictly ascending delay-index table into the beamformer index RAM.
// Once the table is complete and the RAM read path has settled, it raises startbeamformer.
module beamformer_index_loader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int MAX_ENTRIES = 1024,
    parameter int SETTLE      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_index,
    input  logic              cfg_last,
    input  logic              restart,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              startbeamformer,
    output logic              order_error,
    output logic [ADDR_W:0]   entry_count
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0]  SETTLE_INC  = SET_W'(1);
    localparam logic [ADDR_W:0]   MAX_CNT     = (ADDR_W + 1)'(MAX_ENTRIES);
    localparam logic [ADDR_W:0]   CNT_INC     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_INC     = ADDR_W'(1);

    // The beamformer walks the table in order, so equal indices are rejected too.
    function automatic logic idx_ascends(input logic              first,
                                         input logic [DATA_W-1:0] idx,
                                         input logic [DATA_W-1:0] prev);
        idx_ascends = first || (idx > prev);
    endfunction

    state_t              r_state;
    logic                r_cfg_ready;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [DATA_W-1:0]   r_last_idx;
    logic                r_first;
    logic [SET_W-1:0]    r_settle;
    logic [ADDR_W-1:0]   r_ram_address;
    logic [DATA_W-1:0]   r_ram_data;
    logic                r_ram_wren;
    logic                r_start;
    logic                r_order_error;
    logic [ADDR_W:0]     r_entry_count;

    state_t              w_next_state;
    logic                w_write;
    logic                w_bad;
    logic                w_full;
    logic [ADDR_W:0]     w_count_inc;

    // Next-state decode and classification of the current handshake.
    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_bad        = 1'b0;
        w_count_inc  = r_entry_count + CNT_INC;
        w_full       = (w_count_inc == MAX_CNT);
        if (restart) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (cfg_valid && r_cfg_ready) begin
                        if (idx_ascends(r_first, cfg_index, r_last_idx)) begin
                            w_write = 1'b1;
                            if (cfg_last || w_full) begin
                                w_next_state = ST_ARM;
                            end else begin
                                w_next_state = ST_LOAD;
                            end
                        end else begin
                            w_bad        = 1'b1;
                            w_next_state = ST_ERROR;
                        end
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
                ST_ARM: begin
                    if (r_settle == SETTLE_LAST) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_ARM;
                    end
                end
                ST_RUN:   w_next_state = ST_RUN;
                ST_ERROR: w_next_state = ST_ERROR;
                default:  w_next_state = ST_LOAD;
            endcase
        end
    end

    // State register plus the registered handshake/status outputs derived from it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_LOAD;
            r_cfg_ready   <= 1'b1;
            r_start       <= 1'b0;
            r_order_error <= 1'b0;
            r_ram_wren    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cfg_ready   <= (w_next_state == ST_LOAD);
            r_start       <= (w_next_state == ST_RUN);
            r_ram_wren    <= w_write;
            if (restart) begin
                r_order_error <= 1'b0;
            end else if (w_bad) begin
                r_order_error <= 1'b1;
            end else begin
                r_order_error <= r_order_error;
            end
        end
    end

    // Table write path: RAM port registers, write pointer and order tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_wr_ptr      <= '0;
            r_entry_count <= '0;
            r_last_idx    <= '0;
            r_first       <= 1'b1;
        end else if (restart) begin
            r_wr_ptr      <= '0;
            r_entry_count <= '0;
            r_first       <= 1'b1;
        end else if (w_write) begin
            r_ram_address <= r_wr_ptr;
            r_ram_data    <= cfg_index;
            r_entry_count <= w_count_inc;
            r_last_idx    <= cfg_index;
            r_first       <= 1'b0;
            // The final slot of a full table leaves the pointer in range instead of wrapping.
            if (!w_full) begin
                r_wr_ptr <= r_wr_ptr + PTR_INC;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Settle counter covering RAM read latency before the beamformer is enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (restart) begin
            r_settle <= '0;
        end else if (r_state == ST_ARM) begin
            r_settle <= r_settle + SETTLE_INC;
        end else begin
            r_settle <= '0;
        end
    end

    assign cfg_ready       = r_cfg_ready;
    assign ram_address     = r_ram_address;
    assign ram_data        = r_ram_data;
    assign ram_wren        = r_ram_wren;
    assign startbeamformer = r_start;
    assign order_error     = r_order_error;
    assign entry_count     = r_entry_count;

endmodule

// File: tb/tb_beamformer_index_loader.sv
// Directed self-checking bench for beamformer_index_loader with hand-computed expectations.
module tb_beamformer_index_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_index;
    logic        cfg_last;
    logic        restart;
    logic [9:0]  ram_address;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic        startbeamformer;
    logic        order_error;
    logic [10:0] entry_count;

    int n_checks;
    int n_errors;

    beamformer_index_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_index       (cfg_index),
        .cfg_last        (cfg_last),
        .restart         (restart),
        .ram_address     (ram_address),
        .ram_data        (ram_data),
        .ram_wren        (ram_wren),
        .startbeamformer (startbeamformer),
        .order_error     (order_error),
        .entry_count     (entry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake one entry and expect the write it produces in the following cycle.
    task automatic send(input logic [15:0] idx, input logic last, input logic [9:0] exp_addr);
        cfg_valid = 1'b1;
        cfg_index = idx;
        cfg_last  = last;
        step();
        check_eq("wren", 32'(ram_wren), 32'd1);
        check_eq("addr", 32'(ram_address), 32'(exp_addr));
        check_eq("data", 32'(ram_data), 32'(idx));
    endtask

    task automatic pulse_restart();
        cfg_valid = 1'b0;
        restart   = 1'b1;
        step();
        restart = 1'b0;
        check_eq("rst_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_start", 32'(startbeamformer), 32'd0);
        check_eq("rst_err", 32'(order_error), 32'd0);
        check_eq("rst_count", 32'(entry_count), 32'd0);
        check_eq("rst_wren", 32'(ram_wren), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_eq("r_ready", 32'(cfg_ready), 32'd1);
        check_eq("r_wren", 32'(ram_wren), 32'd0);
        check_eq("r_addr", 32'(ram_address), 32'd0);
        check_eq("r_data", 32'(ram_data), 32'd0);
        check_eq("r_start", 32'(startbeamformer), 32'd0);
        check_eq("r_err", 32'(order_error), 32'd0);
        check_eq("r_count", 32'(entry_count), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_index = 16'd0;
        cfg_last  = 1'b0;
        restart   = 1'b0;
        step();
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Basic three-entry table.
        send(16'd5, 1'b0, 10'd0);
        check_eq("t1_ready", 32'(cfg_ready), 32'd1);
        send(16'd9, 1'b0, 10'd1);
        send(16'd20, 1'b1, 10'd2);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check_eq("t1_count", 32'(entry_count), 32'd3);
        check_eq("t1_ready_lo", 32'(cfg_ready), 32'd0);
        check_eq("t1_start_t1", 32'(startbeamformer), 32'd0);
        step();
        check_eq("t1_wren_lo", 32'(ram_wren), 32'd0);
        check_eq("t1_addr_hold", 32'(ram_address), 32'd2);
        check_eq("t1_data_hold", 32'(ram_data), 32'd20);
        check_eq("t1_start_t2", 32'(startbeamformer), 32'd0);
        step();
        check_eq("t1_start_t3", 32'(startbeamformer), 32'd0);
        step();
        check_eq("t1_start_t4", 32'(startbeamformer), 32'd1);
        check_eq("t1_ready_run", 32'(cfg_ready), 32'd0);
        step();
        check_eq("t1_start_hold", 32'(startbeamformer), 32'd1);
        check_eq("t1_count_frz", 32'(entry_count), 32'd3);

        // Restart during RUN, then a fresh two-entry table.
        pulse_restart();
        send(16'd3, 1'b0, 10'd0);
        check_eq("t5_count1", 32'(entry_count), 32'd1);
        send(16'd7, 1'b1, 10'd1);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check_eq("t5_count2", 32'(entry_count), 32'd2);
        step();
        step();
        check_eq("t5_start_t3", 32'(startbeamformer), 32'd0);
        step();
        check_eq("t5_start_t4", 32'(startbeamformer), 32'd1);

        // Equal index is an ordering error.
        pulse_restart();
        send(16'd10, 1'b0, 10'd0);
        cfg_index = 16'd10;
        step();
        cfg_valid = 1'b0;
        check_eq("t2_wren", 32'(ram_wren), 32'd0);
        check_eq("t2_err", 32'(order_error), 32'd1);
        check_eq("t2_ready", 32'(cfg_ready), 32'd0);
        check_eq("t2_count", 32'(entry_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2_err_sticky", 32'(order_error), 32'd1);
            check_eq("t2_start", 32'(startbeamformer), 32'd0);
        end
        pulse_restart();

        // Single-entry table of index zero.
        send(16'h0000, 1'b1, 10'd0);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check_eq("t4_count", 32'(entry_count), 32'd1);
        step();
        step();
        check_eq("t4_start_t3", 32'(startbeamformer), 32'd0);
        step();
        check_eq("t4_start_t4", 32'(startbeamformer), 32'd1);

        // Full table: automatic ARM after 1024 entries; valid during ARM is ignored.
        pulse_restart();
        for (int i = 0; i < 1024; i++) begin
            send(16'(i), 1'b0, 10'(i));
        end
        cfg_index = 16'd2000;
        check_eq("t3_count", 32'(entry_count), 32'd1024);
        check_eq("t3_ready", 32'(cfg_ready), 32'd0);
        step();
        check_eq("t3_arm_nowr", 32'(ram_wren), 32'd0);
        check_eq("t3_addr_hold", 32'(ram_address), 32'd1023);
        step();
        check_eq("t3_start_t3", 32'(startbeamformer), 32'd0);
        step();
        cfg_valid = 1'b0;
        check_eq("t3_start_t4", 32'(startbeamformer), 32'd1);
        check_eq("t3_count_frz", 32'(entry_count), 32'd1024);

        // Reset while in ARM: the beamformer must never be enabled.
        pulse_restart();
        send(16'd1, 1'b0, 10'd0);
        send(16'd2, 1'b1, 10'd1);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        rst_n     = 1'b0;
        step();
        check_reset_outputs();
        step();
        check_eq("t6_start_rst", 32'(startbeamformer), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("t6_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_start_never", 32'(startbeamformer), 32'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
